// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM and
// registers the returned word plus its PC into a single valid/ready output slot.
module instruction_fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter int                INSTR_W  = 28,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               Clock,
   input  logic               Reset,
   output logic [ADDR_W-1:0]  oRomAddress,
   input  logic [INSTR_W-1:0] iRomInstruction,
   input  logic               iRedirect,
   input  logic [ADDR_W-1:0]  iRedirectAddr,
   output logic               oInstrValid,
   input  logic               iInstrReady,
   output logic [INSTR_W-1:0] oInstruction,
   output logic [ADDR_W-1:0]  oInstrPC,
   output logic [15:0]        oFetchCount
);

   typedef enum logic {S_FILL, S_RUN} state_t;

   localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

   state_t             r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic               r_valid;
   logic [INSTR_W-1:0] r_instr;
   logic [ADDR_W-1:0]  r_instr_pc;
   logic [15:0]        r_count;

   logic w_take;
   logic w_free;

   assign w_take = r_valid & iInstrReady;
   assign w_free = ~r_valid | iInstrReady;

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_state    <= S_FILL;
         r_pc       <= RESET_PC;
         r_valid    <= 1'b0;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_count    <= '0;
      end else begin
         // A consumed word counts even when a redirect flushes the slot.
         if (w_take && (r_count != 16'hFFFF))
            r_count <= r_count + 16'd1;

         if (iRedirect) begin
            r_pc    <= iRedirectAddr;
            r_valid <= 1'b0;
            r_state <= S_FILL;
         end else begin
            case (r_state)
               S_FILL: begin
                  r_instr    <= iRomInstruction;
                  r_instr_pc <= r_pc;
                  r_valid    <= 1'b1;
                  r_pc       <= r_pc + PC_ONE;
                  r_state    <= S_RUN;
               end
               S_RUN: begin
                  if (w_free) begin
                     r_instr    <= iRomInstruction;
                     r_instr_pc <= r_pc;
                     r_valid    <= 1'b1;
                     r_pc       <= r_pc + PC_ONE;
                  end
               end
               default: r_state <= S_FILL;
            endcase
         end
      end
   end

   assign oRomAddress  = r_pc;
   assign oInstrValid  = r_valid;
   assign oInstruction = r_instr;
   assign oInstrPC     = r_instr_pc;
   assign oFetchCount  = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios then random traffic, all
// checked against a slot/fetch-pointer model driven by the same inputs.
module tb_instruction_fetch_unit;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] oRomAddress;
   logic [27:0] iRomInstruction;
   logic        iRedirect;
   logic [15:0] iRedirectAddr;
   logic        oInstrValid;
   logic        iInstrReady;
   logic [27:0] oInstruction;
   logic [15:0] oInstrPC;
   logic [15:0] oFetchCount;

   always #5 Clock = ~Clock;

   instruction_fetch_unit #(.ADDR_W(16), .INSTR_W(28), .RESET_PC(16'h0000)) dut (
      .Clock(Clock), .Reset(Reset), .oRomAddress(oRomAddress),
      .iRomInstruction(iRomInstruction), .iRedirect(iRedirect),
      .iRedirectAddr(iRedirectAddr), .oInstrValid(oInstrValid),
      .iInstrReady(iInstrReady), .oInstruction(oInstruction),
      .oInstrPC(oInstrPC), .oFetchCount(oFetchCount)
   );

   logic [31:0] rom_seed;

   // Pseudo-random ROM contents as a pure function of address.
   function automatic logic [27:0] rom_word(input logic [15:0] a);
      logic [31:0] h;
      h = ({16'h0, a} * 32'h9E3779B1) ^ rom_seed;
      h = h ^ (h >> 13);
      return h[27:0];
   endfunction

   assign iRomInstruction = rom_word(oRomAddress);

   // Reference model: next address to fetch, the output slot, accepted count.
   logic [15:0] m_fetch;
   logic        m_valid;
   logic [27:0] m_instr;
   logic [15:0] m_pc;
   int          m_count;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst_n, input logic rdy, input logic redir,
                       input logic [15:0] addr);
      logic take;
      @(negedge Clock);
      Reset = rst_n; iInstrReady = rdy; iRedirect = redir; iRedirectAddr = addr;
      take = m_valid && rdy;
      if (!rst_n) begin
         m_fetch = 16'h0000; m_valid = 1'b0; m_instr = '0; m_pc = '0; m_count = 0;
      end else begin
         if (take && m_count < 65535) m_count++;
         if (redir) begin
            m_fetch = addr;
            m_valid = 1'b0;
         end else if (!m_valid || rdy) begin
            m_pc    = m_fetch;
            m_instr = rom_word(m_fetch);
            m_valid = 1'b1;
            m_fetch = m_fetch + 16'd1;
         end
      end
      @(posedge Clock);
      #1;
      chk("rom_addr", {16'h0, oRomAddress}, {16'h0, m_fetch});
      chk("valid", {31'h0, oInstrValid}, {31'h0, m_valid});
      chk("instr", {4'h0, oInstruction}, {4'h0, m_instr});
      chk("instr_pc", {16'h0, oInstrPC}, {16'h0, m_pc});
      chk("fetch_cnt", {16'h0, oFetchCount}, m_count);
   endtask

   logic [15:0] saved_cnt;

   initial begin
      rom_seed = $urandom;
      Reset = 1'b0; iInstrReady = 1'b0; iRedirect = 1'b0; iRedirectAddr = '0;
      m_fetch = '0; m_valid = 1'b0; m_instr = '0; m_pc = '0; m_count = 0;

      // Reset for three cycles, then stream PCs 0..3.
      repeat (3) step(1'b0, 1'b1, 1'b0, 16'h0);
      chk("rst_valid", {31'h0, oInstrValid}, 32'h0);
      chk("rst_addr", {16'h0, oRomAddress}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0, 16'h0);
         chk("s1_pc", {16'h0, oInstrPC}, i);
         chk("s1_instr", {4'h0, oInstruction}, {4'h0, rom_word(16'(i))});
      end

      // Stall with PC=5 in the slot.
      repeat (2) step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("s2_pc5", {16'h0, oInstrPC}, 32'd5);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b0, 16'h0);
         chk("s2_hold_pc", {16'h0, oInstrPC}, 32'd5);
         chk("s2_hold_addr", {16'h0, oRomAddress}, 32'd6);
         chk("s2_hold_instr", {4'h0, oInstruction}, {4'h0, rom_word(16'd5)});
      end
      step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("s2_pc6", {16'h0, oInstrPC}, 32'd6);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("s2_pc7", {16'h0, oInstrPC}, 32'd7);

      // Redirect to 9 while PC=10 is held and not accepted.
      repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("s3_pc10", {16'h0, oInstrPC}, 32'd10);
      saved_cnt = oFetchCount;
      step(1'b1, 1'b0, 1'b1, 16'd9);
      chk("s3_bubble", {31'h0, oInstrValid}, 32'h0);
      chk("s3_addr9", {16'h0, oRomAddress}, 32'd9);
      chk("s5_cnt_same", {16'h0, oFetchCount}, {16'h0, saved_cnt});
      step(1'b1, 1'b0, 1'b0, 16'h0);
      chk("s3_pc9", {16'h0, oInstrPC}, 32'd9);
      chk("s3_valid", {31'h0, oInstrValid}, 32'h1);

      // Redirect while the slot is accepted: that word still counts.
      saved_cnt = oFetchCount;
      step(1'b1, 1'b1, 1'b1, 16'hFFFF);
      chk("s5_cnt_inc", {16'h0, oFetchCount}, {16'h0, saved_cnt + 16'd1});
      chk("s4_addr", {16'h0, oRomAddress}, 32'h0000FFFF);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("s4_pcffff", {16'h0, oInstrPC}, 32'h0000FFFF);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("s4_pc0000", {16'h0, oInstrPC}, 32'h0);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("s4_pc0001", {16'h0, oInstrPC}, 32'h1);

      // Reset mid-stream at PC=12 with a concurrent redirect.
      step(1'b1, 1'b1, 1'b1, 16'd10);
      repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("s6_pc12", {16'h0, oInstrPC}, 32'd12);
      step(1'b0, 1'b1, 1'b1, 16'h1234);
      chk("s6_valid", {31'h0, oInstrValid}, 32'h0);
      chk("s6_addr", {16'h0, oRomAddress}, 32'h0);
      chk("s6_cnt", {16'h0, oFetchCount}, 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic rst_n, rdy, redir;
         logic [15:0] addr;
         rst_n = ($urandom_range(0, 199) != 0);
         rdy   = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 9) == 0);
         addr  = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 3))
                                             : 16'($urandom);
         step(rst_n, rdy, redir, addr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
